dmem_lsu: RTL and testbench



---
 rtl/dmem_lsu_pkg.sv | 32 +++
 rtl/dmem_lsu_lane.sv | 33 +++
 rtl/dmem_lsu.sv | 145 ++++++++++++++
 tb/tb_dmem_lsu.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_DATA = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    function automatic logic [3:0] size_bytes(size_e s);
        return 4'd1 << s;
    endfunction

    function automatic logic [63:0] size_mask(size_e s);
        case (s)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// Byte-lane datapath: load extract with sign/zero extension, and the
// read-modify-write merge used for sub-dword stores.
module dmem_lsu_lane
    import dmem_lsu_pkg::*;
(
    input  logic [63:0] ram_dout,
    input  logic [63:0] wdata,
    input  logic [2:0]  offset,
    input  size_e       size,
    input  logic        zero_ext,
    output logic [63:0] rdata,
    output logic [63:0] merged
);

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] mask;

    always_comb begin
        shamt   = {offset, 3'b000};
        shifted = ram_dout >> shamt;
        mask    = size_mask(size);
        rdata   = shifted;
        case (size)
            SZ_B: rdata = zero_ext ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            SZ_H: rdata = zero_ext ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W: rdata = zero_ext ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: rdata = shifted;
        endcase
        merged = (ram_dout & ~(mask << shamt)) | ((wdata & mask) << shamt);
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving port B of the 64-bit data RAM; sub-dword stores
// are done as read-modify-write because the RAM has no byte enables.
//
// state   | meaning
// IDLE    | ready for a request
// RD      | word address presented to the RAM
// DATA    | RAM read data valid; extract load or merge store
// WR      | RAM write strobe
// RESP    | one-cycle response pulse
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int RAM_WIDTH = 64,
    parameter int RAM_DEPTH = 512,
    localparam int RAM_AW = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [RAM_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [RAM_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic [RAM_WIDTH-1:0] ram_din,
    output logic                 ram_we,
    input  logic [RAM_WIDTH-1:0] ram_dout
);

    state_e                 state_q, state_d;
    logic [2:0]             off_q;
    logic                   we_q;
    size_e                  size_q;
    logic                   uns_q;
    logic [RAM_WIDTH-1:0]   wdata_q;
    logic [RAM_AW-1:0]      ram_addr_q;
    logic [RAM_WIDTH-1:0]   ram_din_q;
    logic [RAM_WIDTH-1:0]   rsp_rdata_q;
    logic                   rsp_err_q;

    size_e                  req_sz;
    logic [2:0]             align_mask;
    logic                   handshake;
    logic                   req_err;
    logic [RAM_WIDTH-1:0]   load_data;
    logic [RAM_WIDTH-1:0]   merged;

    assign req_sz     = size_e'(req_size);
    assign align_mask = 3'(size_bytes(req_sz) - 4'd1);
    assign req_ready  = (state_q == ST_IDLE);
    assign handshake  = req_valid & req_ready;
    assign req_err    = ((req_addr[2:0] & align_mask) != 3'd0) ||
                        ((req_addr >> (RAM_AW + 3)) != 32'd0);

    dmem_lsu_lane u_lane (
        .ram_dout (ram_dout),
        .wdata    (wdata_q),
        .offset   (off_q),
        .size     (size_q),
        .zero_ext (uns_q),
        .rdata    (load_data),
        .merged   (merged)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    if (req_err)                         state_d = ST_RESP;
                    else if (req_we && req_sz == SZ_D)   state_d = ST_WR;
                    else                                 state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_DATA;
            ST_DATA: state_d = we_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM address/data are registered on entry to RD/WR so they hold between accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            off_q       <= 3'd0;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (handshake) begin
                        off_q   <= req_addr[2:0];
                        we_q    <= req_we;
                        size_q  <= req_sz;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            ram_addr_q <= req_addr[RAM_AW+2:3];
                            if (req_we && req_sz == SZ_D)
                                ram_din_q <= req_wdata;
                        end
                    end
                end
                ST_DATA: begin
                    if (we_q) begin
                        ram_din_q <= merged;
                    end else begin
                        rsp_rdata_q <= load_data;
                        rsp_err_q   <= 1'b0;
                    end
                end
                ST_WR: begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ram_we    = (state_q == ST_WR);
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu with a port-B RAM model and a byte-array reference.
module tb_dmem_lsu;

    localparam int DEPTH = 512;
    localparam int NBYTES = DEPTH * 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [8:0]  ram_addr;
    logic [63:0] ram_din;
    logic        ram_we;
    logic [63:0] ram_dout;

    int tests = 0;
    int fails = 0;

    logic        ram_init = 1'b1;
    logic [63:0] mem [DEPTH];
    logic [7:0]  ref_mem [NBYTES];
    int          we_cnt = 0;
    int          rsp_cnt = 0;
    logic [8:0]  last_we_addr = '0;

    dmem_lsu #(.RAM_WIDTH(64), .RAM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .ram_dout     (ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous read-first RAM port B.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ram_dout <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_we) begin
            we_cnt = we_cnt + 1;
            last_we_addr = ram_addr;
        end
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    end

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
        int n = 1 << sz;
        return ((a % n) != 0) || (a >= NBYTES);
    endfunction

    function automatic logic [63:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        int n = 1 << sz;
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[a + i]) << (8 * i));
        if (!uns && n < 8 && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic issue(input logic [31:0] a, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [63:0] wd, output logic [63:0] rd, output bit err,
                         output int lat, output int wes);
        bit ok;
        int w0;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL req_ready_timeout: req_ready=%0b, required 1 within 20 cycles", req_ready);
        end
        w0 = we_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = k; break; end
        end
        rd  = rsp_rdata;
        err = rsp_err;
        wes = we_cnt - w0;
        if (we && !model_err(a, sz)) begin
            n = 1 << sz;
            for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8 * i +: 8];
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        ram_init = 1'b0;
        tests++;
        if (ram_we !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes: ram_we=%b rsp_valid=%b, required 0 0", ram_we, rsp_valid);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 64'd0 ||
            ram_addr !== 9'd0 || ram_din !== 64'd0) begin
            fails++;
            $display("FAIL reset_values: ready=%b err=%b rdata=%h addr=%h din=%h, required 1 0 0 0 0",
                     req_ready, rsp_err, rsp_rdata, ram_addr, ram_din);
        end
    endtask

    task automatic test_store_dword();
        logic [63:0] rd; bit err; int lat, wes;
        issue(32'd16, 1'b1, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, rd, err, lat, wes);
        tests++;
        if (lat !== 2 || wes !== 1 || last_we_addr !== 9'd2 || err !== 1'b0) begin
            fails++;
            $display("FAIL sd_timing: lat=%0d wes=%0d addr=%0d err=%b, required 2 1 2 0",
                     lat, wes, last_we_addr, err);
        end
        issue(32'd16, 1'b0, 2'd3, 1'b0, 64'd0, rd, err, lat, wes);
        tests++;
        if (rd !== 64'h0123_4567_89AB_CDEF || lat !== 3 || wes !== 0) begin
            fails++;
            $display("FAIL ld_after_sd: rdata=%h lat=%0d wes=%0d, required 0123456789abcdef 3 0", rd, lat, wes);
        end
    endtask

    task automatic test_sign_ext();
        logic [63:0] rd; bit err; int lat, wes;
        logic [31:0] addrs [4] = '{32'd7, 32'd7, 32'd6, 32'd4};
        logic [1:0]  sizes [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
        bit          unss  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [63:0] exps  [4] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h0000_0000_0000_0088,
                                   64'hFFFF_FFFF_FFFF_8877, 64'hFFFF_FFFF_8877_6655};
        issue(32'd0, 1'b1, 2'd3, 1'b0, 64'h8877_6655_4433_2211, rd, err, lat, wes);
        for (int i = 0; i < 4; i++) begin
            issue(addrs[i], 1'b0, sizes[i], unss[i], 64'd0, rd, err, lat, wes);
            tests++;
            if (rd !== exps[i] || lat !== 3 || err !== 1'b0) begin
                fails++;
                $display("FAIL sign_ext_%0d: rdata=%h lat=%0d err=%b, required %h 3 0", i, rd, lat, err, exps[i]);
            end
        end
    endtask

    task automatic test_sub_store();
        logic [63:0] rd; bit err; int lat, wes;
        issue(32'd8, 1'b1, 2'd3, 1'b0, 64'd0, rd, err, lat, wes);
        issue(32'd9, 1'b1, 2'd0, 1'b0, 64'h0000_0000_0000_00AB, rd, err, lat, wes);
        tests++;
        if (wes !== 1 || lat !== 4 || rd !== 64'd0) begin
            fails++;
            $display("FAIL sb_store: wes=%0d lat=%0d rdata=%h, required 1 4 0", wes, lat, rd);
        end
        issue(32'd12, 1'b1, 2'd1, 1'b0, 64'h0000_0000_0000_CDEF, rd, err, lat, wes);
        tests++;
        if (wes !== 1 || lat !== 4) begin
            fails++;
            $display("FAIL sh_store: wes=%0d lat=%0d, required 1 4", wes, lat);
        end
        issue(32'd8, 1'b0, 2'd3, 1'b0, 64'd0, rd, err, lat, wes);
        tests++;
        if (rd !== 64'h0000_CDEF_0000_AB00) begin
            fails++;
            $display("FAIL sub_merge: word1=%h, required 0000cdef0000ab00", rd);
        end
    endtask

    task automatic test_errors();
        logic [63:0] rd; bit err; int lat, wes;
        issue(32'd0, 1'b0, 2'd3, 1'b0, 64'd0, rd, err, lat, wes);
        issue(32'd2, 1'b0, 2'd2, 1'b0, 64'd0, rd, err, lat, wes);
        tests++;
        if (err !== 1'b1 || rd !== 64'd0 || lat !== 1 || wes !== 0) begin
            fails++;
            $display("FAIL lw_misaligned: err=%b rdata=%h lat=%0d wes=%0d, required 1 0 1 0", err, rd, lat, wes);
        end
        issue(NBYTES, 1'b1, 2'd0, 1'b0, 64'hFF, rd, err, lat, wes);
        tests++;
        if (err !== 1'b1 || lat !== 1 || wes !== 0) begin
            fails++;
            $display("FAIL sb_out_of_range: err=%b lat=%0d wes=%0d, required 1 1 0", err, lat, wes);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; bit err; int lat, wes;
        int w0, r0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'd0; req_we = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 64'h55;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_ready: req_ready=%b, required 1", req_ready);
        end
        w0 = we_cnt; r0 = rsp_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (we_cnt !== w0 || rsp_cnt !== r0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: wes=%0d rsps=%0d ready=%b, required 0 0 1",
                     we_cnt - w0, rsp_cnt - r0, req_ready);
        end
        issue(32'd0, 1'b0, 2'd3, 1'b0, 64'd0, rd, err, lat, wes);
        tests++;
        if (rd !== 64'h8877_6655_4433_2211) begin
            fail_word0: begin
                fails++;
                $display("FAIL reset_mid_word0: word0=%h, required 8877665544332211", rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hs = 0;
        int rs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_addr = 32'd16; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
                req_valid = 1'b1;
            end
            tests++;
            if (req_ready !== ((i % 4) == 0)) begin
                fails++;
                $display("FAIL b2b_ready_%0d: req_ready=%b, required %b", i, req_ready, (i % 4) == 0);
            end
            if (req_valid && req_ready) hs++;
            if (rsp_valid) begin
                rs++;
                tests++;
                if (rsp_rdata !== 64'h0123_4567_89AB_CDEF) begin
                    fails++;
                    $display("FAIL b2b_rdata_%0d: rdata=%h, required 0123456789abcdef", i, rsp_rdata);
                end
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if (hs !== 5 || rs !== 5) begin
            fails++;
            $display("FAIL b2b_counts: handshakes=%0d responses=%0d, required 5 5", hs, rs);
        end
    endtask

    task automatic test_random();
        logic [63:0] rd, wd, exp_rd; bit err, exp_err, we, uns; int lat, wes, exp_lat;
        logic [31:0] a; logic [1:0] sz; int r;
        for (int t = 0; t < 1000; t++) begin
            we  = 1'($urandom % 2);
            sz  = 2'($urandom % 4);
            uns = 1'($urandom % 2);
            wd  = {$urandom, $urandom};
            a   = 32'($urandom_range(0, NBYTES - 1));
            r   = int'($urandom % 8);
            if (r < 6) a = a & ~32'((1 << sz) - 1);
            if (r == 7) a = a | (32'd1 << $urandom_range(12, 31));
            exp_err = model_err(a, sz);
            exp_rd  = (exp_err || we) ? 64'd0 : model_load(a, sz, uns);
            exp_lat = exp_err ? 1 : (!we ? 3 : (sz == 2'd3 ? 2 : 4));
            issue(a, we, sz, uns, wd, rd, err, lat, wes);
            tests++;
            if (rd !== exp_rd || err !== exp_err || lat !== exp_lat) begin
                fails++;
                $display("FAIL rand_%0d: addr=%h we=%b sz=%0d rdata=%h err=%b lat=%0d, required %h %b %0d",
                         t, a, we, sz, rd, err, lat, exp_rd, exp_err, exp_lat);
            end
            tests++;
            if (wes !== ((we && !exp_err) ? 1 : 0)) begin
                fails++;
                $display("FAIL rand_we_%0d: ram_we cycles=%0d, required %0d", t, wes, (we && !exp_err) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_dword();
        test_sign_ext();
        test_sub_store();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
